// File: rtl/generic_apb_master_if.sv
// Command/response and APB bus bundle for generic_apb_master.
// master modport: the bridge's view. slave modport: the view of the command
// source together with the APB peripheral.
interface generic_apb_master_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] apm_m0_paddr;
  logic              apm_m0_psel;
  logic              apm_m0_penable;
  logic              apm_m0_pwrite;
  logic [DATA_W-1:0] apm_m0_pwdata;
  logic [DATA_W-1:0] apm_m0_prdata;
  logic              apm_m0_pready;
  logic              apm_m0_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  apm_m0_prdata, apm_m0_pready, apm_m0_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output apm_m0_paddr, apm_m0_psel, apm_m0_penable, apm_m0_pwrite, apm_m0_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output apm_m0_prdata, apm_m0_pready, apm_m0_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  apm_m0_paddr, apm_m0_psel, apm_m0_penable, apm_m0_pwrite, apm_m0_pwdata
  );
endinterface

// File: rtl/generic_apb_master.sv
// APB3 requester: turns one-at-a-time commands into SETUP/ACCESS transfers,
// honours pready wait states and reports pslverr with a one-cycle response.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// cycles without pready (response then carries rsp_err = 1, rsp_rdata = 0).
module generic_apb_master #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 clock_clk,
  input logic                 reset_n,
  generic_apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_EFF = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W  = ($clog2(TO_EFF + 1) > 8) ? $clog2(TO_EFF + 1) : 8;
  // cnt_q counts wait cycles already spent, so the limit is hit on the
  // TO_EFF-th ACCESS cycle that still sees pready low.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EFF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (bus.apm_m0_pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.apm_m0_prdata;
          rsp_err_d   = bus.apm_m0_pslverr;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q >= TO_LAST) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops psel/penable immediately.
  always_ff @(posedge clock_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.cmd_ready      = (state_q == IDLE);
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.apm_m0_paddr   = paddr_q;
  assign bus.apm_m0_psel    = psel_q;
  assign bus.apm_m0_penable = penable_q;
  assign bus.apm_m0_pwrite  = pwrite_q;
  assign bus.apm_m0_pwdata  = pwdata_q;

endmodule

// File: doc/generic_apb_master.md
Name: generic_apb_master

Overview:
- APB3 requester (initiator) bridge: converts a simple one-at-a-time command/response interface into APB SETUP/ACCESS transactions.
- Drives the APB side of slave peripherals built to the team's APB register interface (e.g. the generic APB IO block).
- Honours pready wait states and reports pslverr.
- Sits between internal control logic (sequencers, DSP parameter loaders) and the APB peripheral bus.

Parameters:
- ADDR_W, 5, APB address width (paddr and cmd_addr).
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- clock_clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  transaction address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  output  DATA_W  read data; 0 for writes.
- rsp_err  output  1  pslverr or timeout seen.
- apm_m0_paddr  output  ADDR_W  APB paddr.
- apm_m0_psel  output  1  APB psel.
- apm_m0_penable  output  1  APB penable.
- apm_m0_pwrite  output  1  APB pwrite.
- apm_m0_pwdata  output  DATA_W  APB pwdata.
- apm_m0_prdata  input  DATA_W  APB prdata.
- apm_m0_pready  input  1  APB pready.
- apm_m0_pslverr  input  1  APB pslverr; tie 0 if the slave lacks it.

Behaviour:
- Reset values: all outputs registered and cleared to 0 while reset_n = 0; state = IDLE. Exception: cmd_ready = (state == IDLE), so it reads 1 during reset.
- Reset mid-transaction: psel/penable drop asynchronously; no rsp_valid is issued for the aborted command.
- IDLE: cmd_ready = 1, psel = 0, penable = 0.
  - On cmd_valid: latch cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata; go to SETUP.
  - For reads, pwdata holds its previous value.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; then ACCESS.
- ACCESS: psel = 1, penable = 1; paddr, pwrite and pwdata stable.
  - pready = 0 at a clock edge: stay in ACCESS.
  - pready = 1 at a clock edge: sample prdata (reads only, else 0) into rsp_rdata; sample pslverr into rsp_err; assert rsp_valid for the next cycle; go to IDLE.
  - psel/penable deassert in that same next cycle.
- Latency: with zero wait states, rsp_valid is high 3 cycles after the accept edge. Each wait state adds 1 cycle.
- Back-to-back: a new command may be accepted in the cycle rsp_valid is high. Minimum issue interval is 3 cycles.
- rsp_rdata and rsp_err hold their values until the next completion. rsp_valid is high for exactly one cycle per accepted command.
- cmd_* inputs are ignored outside IDLE. No queueing; cmd_ready = 0 in SETUP and ACCESS.
- pslverr is ignored unless pready = 1. prdata is ignored on writes.
- paddr, pwrite and pwdata retain the last transaction's values in IDLE; they never glitch.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - An 8-bit-minimum saturating counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0: go to IDLE (psel/penable low next cycle) and pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0.
  - pready = 1 on the same edge as the limit wins: normal completion.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Write, zero wait: cmd write addr=0x04 wdata=0xDEADBEEF, slave pready=1 -> one SETUP cycle (psel=1, penable=0), one ACCESS cycle, pwdata=0xDEADBEEF; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read, 2 wait states: addr=0x08, slave returns 0x12345678 after 2 pready=0 cycles -> ACCESS lasts 3 cycles; rsp_rdata=0x12345678 at rsp_valid (5 cycles after accept).
- Slave error: read with pslverr=1 on the pready cycle -> rsp_err=1; next command with pslverr=0 -> rsp_err=0.
- Back-to-back: cmd_valid held high with 3 queued writes -> accepts spaced exactly 3 cycles apart, 3 rsp_valid pulses; psel is low for one cycle between transactions.
- Reset mid-ACCESS: assert reset_n=0 while penable=1 -> psel/penable=0 immediately, no rsp_valid; after release cmd_ready=1 and the next read completes normally.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0; without the macro, the bench confirms ACCESS persists for 100 cycles.
